// File: rtl/dither_seq_pkg.sv
// rtl/dither_seq_pkg.sv - state codes and relock counter sizing for the relock sequencer
package dither_seq_pkg;

  localparam int STATE_W  = 3;
  localparam int RELOCK_W = 8;
  localparam logic [RELOCK_W-1:0] RELOCK_SAT = 8'd255;

  typedef enum logic [STATE_W-1:0] {
    IDLE   = 3'd0,
    SWEEP  = 3'd1,
    ENGAGE = 3'd2,
    LOCKED = 3'd3,
    FAULT  = 3'd4
  } state_t;

endpackage

// File: rtl/sweep_ramp_gen.sv
// rtl/sweep_ramp_gen.sv - prescaled, clamped triangle ramp for the lock-acquisition offset
module sweep_ramp_gen #(
  parameter int          N_B    = 16,
  parameter logic [15:0] N_TICK = 16'd100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  hold,
  input  logic                  restart,
  input  logic                  load_min,
  input  logic signed [N_B-1:0] sweep_min,
  input  logic signed [N_B-1:0] sweep_max,
  input  logic        [N_B-1:0] sweep_step,
  output logic signed [N_B-1:0] sweep_out
);

  // Two guard bits so a full-scale step from a full-scale value cannot wrap.
  localparam int W = N_B + 2;

  logic        [15:0]  presc_q, presc_d;
  logic                dir_up_q, dir_up_d;
  logic signed [N_B-1:0] out_q, out_d;
  logic signed [W-1:0] cur_x, step_x, min_x, max_x, up_x, dn_x;

  always_comb begin
    presc_d  = presc_q;
    dir_up_d = dir_up_q;
    out_d    = out_q;
    cur_x    = {{2{out_q[N_B-1]}}, out_q};
    step_x   = {2'b00, sweep_step};
    min_x    = {{2{sweep_min[N_B-1]}}, sweep_min};
    max_x    = {{2{sweep_max[N_B-1]}}, sweep_max};
    up_x     = cur_x + step_x;
    dn_x     = cur_x - step_x;
    if (load_min) begin
      out_d    = sweep_min;
      dir_up_d = 1'b1;
      presc_d  = '0;
    end else if (restart) begin
      presc_d = '0;
    end else if (!hold) begin
      if (presc_q == N_TICK - 16'd1) presc_d = '0;
      else                           presc_d = presc_q + 16'd1;
      if (sweep_min >= sweep_max) begin
        out_d = sweep_min;
      end else if (presc_q == N_TICK - 16'd1) begin
        if (dir_up_q) begin
          if (up_x >= max_x) begin
            out_d    = sweep_max;
            dir_up_d = 1'b0;
          end else begin
            out_d = up_x[N_B-1:0];
          end
        end else begin
          if (dn_x <= min_x) begin
            out_d    = sweep_min;
            dir_up_d = 1'b1;
          end else begin
            out_d = dn_x[N_B-1:0];
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q  <= '0;
      dir_up_q <= 1'b1;
      out_q    <= '0;
    end else begin
      presc_q  <= presc_d;
      dir_up_q <= dir_up_d;
      out_q    <= out_d;
    end
  end

  assign sweep_out = out_q;

endmodule

// File: rtl/dither_relock_sequencer.sv
// rtl/dither_relock_sequencer.sv - sweep/engage/lock/relock FSM for the dither-lock servo
// Optional error-magnitude gate on engage and settling: RELOCK_ERRGATE_EN.
module dither_relock_sequencer
  import dither_seq_pkg::*;
#(
  parameter int          N_B        = 16,
  parameter logic [15:0] N_TICK     = 16'd100,
  parameter logic [23:0] N_SETTLE   = 24'd2_000_000,
  parameter logic [15:0] N_LOSS     = 16'd1000,
  parameter logic [7:0]  MAX_RELOCK = 8'd16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic signed [N_B-1:0]  sig_in,
  input  logic signed [N_B-1:0]  demod,
  input  logic signed [N_B-1:0]  lock_thresh,
  input  logic        [N_B-1:0]  err_thresh,
  input  logic signed [N_B-1:0]  sweep_min,
  input  logic signed [N_B-1:0]  sweep_max,
  input  logic        [N_B-1:0]  sweep_step,
  input  logic                   DITHon,
  output logic                   PID_on,
  output logic signed [N_B-1:0]  sweep_out,
  output logic [STATE_W-1:0]     state,
  output logic                   locked,
  output logic [RELOCK_W-1:0]    relock_count
);

  state_t                state_q, state_d;
  logic [23:0]           settle_q, settle_d;
  logic [15:0]           loss_q, loss_d;
  logic [RELOCK_W-1:0]   relock_q, relock_d;
  logic                  pid_on_q, pid_on_d;
  logic                  locked_q, locked_d;
  logic                  above, gate_ok, advance;

  assign above = (sig_in >= lock_thresh);

`ifdef RELOCK_ERRGATE_EN
  // Magnitude in N_B+1 bits so the most negative code maps to +2^(N_B-1).
  logic [N_B:0] demod_abs;
  assign demod_abs = demod[N_B-1] ? (~{demod[N_B-1], demod} + 1'b1) : {1'b0, demod};
  assign gate_ok   = (demod_abs <= {1'b0, err_thresh});
`else
  logic unused_gate;
  assign unused_gate = &{1'b0, demod, err_thresh};
  assign gate_ok     = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    settle_d = (state_q == ENGAGE) ? settle_q : '0;
    loss_d   = (state_q == LOCKED) ? loss_q : '0;
    relock_d = relock_q;
    advance  = 1'b0;
    if (!enable) begin
      state_d  = IDLE;
      relock_d = '0;
    end else begin
      case (state_q)
        IDLE: begin
          state_d  = SWEEP;
          relock_d = '0;
        end
        SWEEP: begin
          if (above && gate_ok) state_d = ENGAGE;
          else                  advance = 1'b1;
        end
        ENGAGE: begin
          if (!above) begin
            state_d  = SWEEP;
            settle_d = '0;
          end else if (!DITHon || !gate_ok) begin
            settle_d = '0;
          end else if (settle_q == N_SETTLE - 24'd1) begin
            state_d  = LOCKED;
            settle_d = '0;
          end else begin
            settle_d = settle_q + 24'd1;
          end
        end
        LOCKED: begin
          if (above) begin
            loss_d = '0;
          end else if (loss_q == N_LOSS - 16'd1) begin
            loss_d   = '0;
            relock_d = (relock_q == RELOCK_SAT) ? relock_q : relock_q + 8'd1;
            state_d  = (relock_d == MAX_RELOCK) ? FAULT : SWEEP;
          end else begin
            loss_d = loss_q + 16'd1;
          end
        end
        FAULT:   state_d = FAULT;
        default: state_d = IDLE;
      endcase
    end
    pid_on_d = (state_d == ENGAGE) || (state_d == LOCKED);
    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      settle_q <= '0;
      loss_q   <= '0;
      relock_q <= '0;
      pid_on_q <= 1'b0;
      locked_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      loss_q   <= loss_d;
      relock_q <= relock_d;
      pid_on_q <= pid_on_d;
      locked_q <= locked_d;
    end
  end

  // The ramp only moves on cycles that stay in SWEEP; any exit freezes it.
  sweep_ramp_gen #(
    .N_B    (N_B),
    .N_TICK (N_TICK)
  ) u_ramp (
    .clk        (clk),
    .rst        (rst),
    .hold       (!advance),
    .restart    (state_q != SWEEP),
    .load_min   ((state_q == IDLE) || (state_d == IDLE)),
    .sweep_min  (sweep_min),
    .sweep_max  (sweep_max),
    .sweep_step (sweep_step),
    .sweep_out  (sweep_out)
  );

  assign state        = state_q;
  assign PID_on       = pid_on_q;
  assign locked       = locked_q;
  assign relock_count = relock_q;

endmodule
